// File: rtl/debouncer_ctrl_pkg.sv
// debouncer_ctrl_pkg: register offsets and edge-field layout shared by the debouncer controller
package debouncer_ctrl_pkg;
    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_IRQ_EN  = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_PRESC   = 2'd3;
    localparam int FALL_SHIFT  = 16;
    localparam int MAX_EDGE_CH = 16;
endpackage

// File: rtl/debouncer_channel.sv
// debouncer_channel: one input's stability counter; commits a new stable level after 2^CNT_WIDTH ticks without a glitch
module debouncer_channel #(
    parameter int CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in_sync,
    output logic stable,
    output logic rise,
    output logic fall
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d;
    logic differ, commit;
    assign differ   = in_sync ^ stable_q;
    assign commit   = differ & tick & (&cnt_q);
    assign stable_d = commit ? in_sync : stable_q;
    assign cnt_d    = (!differ || commit) ? '0 : tick ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end
    assign stable = stable_q;
    assign rise   = commit & in_sync;
    assign fall   = commit & ~in_sync;
endmodule

// File: rtl/debouncer_ctrl.sv
// debouncer_ctrl: multi-channel debouncer with Wishbone registers and level irq
// Falling-edge tracking (PENDING/IRQ_EN bits [31:16]) is built only with DEBOUNCER_CTRL_FALLING_EN.
module debouncer_ctrl
    import debouncer_ctrl_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int CNT_WIDTH   = 4,
    parameter int PRESC_WIDTH = 16,
    parameter logic [PRESC_WIDTH-1:0] PRESC_RESET = PRESC_WIDTH'(999)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    input  logic                wb_we,
    input  logic [3:0]          wb_adr,
    input  logic [31:0]         wb_dat_w,
    input  logic [3:0]          wb_sel,
    output logic [31:0]         wb_dat_r,
    output logic                wb_ack,
    output logic                irq
);
    localparam int EDGE_CH = (CHANNELS < MAX_EDGE_CH) ? CHANNELS : MAX_EDGE_CH;
    localparam logic [31:0] RISE_MASK = 32'((64'd1 << EDGE_CH) - 64'd1);
`ifdef DEBOUNCER_CTRL_FALLING_EN
    localparam logic [31:0] IMPL_MASK = RISE_MASK | (RISE_MASK << FALL_SHIFT);
`else
    localparam logic [31:0] IMPL_MASK = RISE_MASK;
`endif

    logic [CHANNELS-1:0] sync1_q, sync2_q, stable, rise, fall;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    logic [31:0] wm, wdat_m, en_q, en_d, pend_q, pend_d, ev, rdata, dat_r_q;
    logic [1:0] reg_sel;
    logic req, new_req, wr, presc_wr, tick, served_q, ack_q, irq_q;
    logic unused_adr;

    assign unused_adr = ^wb_adr[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debouncer_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk(clk), .rst(rst), .tick(tick), .in_sync(sync2_q[g]),
            .stable(stable[g]), .rise(rise[g]), .fall(fall[g])
        );
    end

    // A held request is served once; the master must drop stb before the next access.
    assign req      = wb_cyc & wb_stb;
    assign new_req  = req & ~served_q;
    assign wr       = new_req & wb_we;
    assign reg_sel  = wb_adr[3:2];
    assign wm       = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    assign wdat_m   = wb_dat_w & wm;
    assign presc_wr = wr && reg_sel == REG_PRESC;

    assign presc_d = presc_wr ? (presc_q & ~wm[PRESC_WIDTH-1:0]) | wdat_m[PRESC_WIDTH-1:0] : presc_q;
    assign tick    = pcnt_q == '0 && !presc_wr;
    assign pcnt_d  = presc_wr ? presc_d : (pcnt_q == '0) ? presc_q : pcnt_q - PRESC_WIDTH'(1);

    // Hardware events are OR-ed in after the W1C clear so a coincident set survives.
    assign ev     = (32'(rise) | (32'(fall) << FALL_SHIFT)) & IMPL_MASK;
    assign en_d   = (wr && reg_sel == REG_IRQ_EN) ? ((en_q & ~wm) | wdat_m) & IMPL_MASK : en_q;
    assign pend_d = (pend_q & ~((wr && reg_sel == REG_PENDING) ? wdat_m : 32'd0)) | ev;

    assign rdata = (reg_sel == REG_STATE)   ? 32'(stable) :
                   (reg_sel == REG_IRQ_EN)  ? en_q :
                   (reg_sel == REG_PENDING) ? pend_q : 32'(presc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            presc_q  <= PRESC_RESET;
            pcnt_q   <= PRESC_RESET;
            en_q     <= '0;
            pend_q   <= '0;
            served_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_r_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync1_q  <= in;
            sync2_q  <= sync1_q;
            presc_q  <= presc_d;
            pcnt_q   <= pcnt_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            served_q <= req;
            ack_q    <= new_req;
            dat_r_q  <= new_req ? rdata : '0;
            irq_q    <= |(pend_q & en_q);
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_r = dat_r_q;
    assign irq      = irq_q;
endmodule
